// File: rtl/alu_instr_sequencer.sv
// Hardwired T0-T5 control sequencer for fetch and execution of R-format ALU
// instructions; drives the datapath control ports straight from the state register and IR.
module alu_instr_sequencer #(
    parameter int NREGS = 16
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic             Run,
    input  logic [31:0]      IR,
    input  logic             Mem_ready,
    output logic             PCout,
    output logic             Zlowout,
    output logic             Zhighout,
    output logic             MDRout,
    output logic             MARin,
    output logic             Zin,
    output logic             PCin,
    output logic             MDRin,
    output logic             IRin,
    output logic             Yin,
    output logic             IncPC,
    output logic             Read,
    output logic [3:0]       CONTROL,
    output logic [NREGS-1:0] Rin,
    output logic [NREGS-1:0] Rout,
    output logic             Busy,
    output logic             Done,
    output logic             Illegal
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_T0   = 3'd1;
    localparam logic [2:0] S_T1   = 3'd2;
    localparam logic [2:0] S_T2   = 3'd3;
    localparam logic [2:0] S_T3   = 3'd4;
    localparam logic [2:0] S_T4   = 3'd5;
    localparam logic [2:0] S_T5   = 3'd6;

    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic [4:0]       opcode;
    logic [3:0]       ra_field;
    logic [3:0]       rb_field;
    logic [3:0]       rc_field;
    logic             op_legal;
    logic [3:0]       op_control;
    logic [NREGS-1:0] ra_onehot;
    logic [NREGS-1:0] rb_onehot;
    logic [NREGS-1:0] rc_onehot;
    logic             unused_ir_bits;

    assign opcode         = IR[31:27];
    assign ra_field       = IR[26:23];
    assign rb_field       = IR[22:19];
    assign rc_field       = IR[18:15];
    assign unused_ir_bits = &{1'b0, IR[14:0]};

    // Shifting past the top of a narrower register file leaves the enable all-zero.
    assign ra_onehot = NREGS'(1) << ra_field;
    assign rb_onehot = NREGS'(1) << rb_field;
    assign rc_onehot = NREGS'(1) << rc_field;

    always_comb begin
        op_legal   = 1'b1;
        op_control = 4'b0000;
        case (opcode)
            5'b01001: op_control = 4'b0000;
            5'b01010: op_control = 4'b0001;
            5'b00011: op_control = 4'b0010;
            5'b00100: op_control = 4'b0011;
            5'b00101: op_control = 4'b0100;
            5'b00110: op_control = 4'b0101;
            default:  op_legal   = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (Run) state_d = S_T0;
            S_T0:    state_d = S_T1;
            S_T1:    if (Mem_ready) state_d = S_T2;
            S_T2:    state_d = S_T3;
            S_T3:    state_d = op_legal ? S_T4 : S_IDLE;
            S_T4:    state_d = S_T5;
            S_T5:    state_d = Run ? S_T0 : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Zhighout stays low; it is held for a future MUL/DIV extension.
    always_comb begin
        PCout    = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        MDRout   = 1'b0;
        MARin    = 1'b0;
        Zin      = 1'b0;
        PCin     = 1'b0;
        MDRin    = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        IncPC    = 1'b0;
        Read     = 1'b0;
        CONTROL  = 4'b0000;
        Rin      = '0;
        Rout     = '0;
        Done     = 1'b0;
        Illegal  = 1'b0;
        Busy     = (state_q != S_IDLE);
        case (state_q)
            S_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                if (op_legal) begin
                    Rout = rb_onehot;
                    Yin  = 1'b1;
                end else begin
                    Illegal = 1'b1;
                end
            end
            S_T4: begin
                Rout    = rc_onehot;
                Zin     = 1'b1;
                CONTROL = op_control;
            end
            S_T5: begin
                Zlowout = 1'b1;
                Rin     = ra_onehot;
                Done    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Directed self-checking bench for alu_instr_sequencer: reset, AND, memory stall,
// back-to-back ADD, illegal opcode and asynchronous clear mid-instruction.
module tb_alu_instr_sequencer;

    localparam logic [14:0] F_PCOUT   = 15'h4000;
    localparam logic [14:0] F_ZLOWOUT = 15'h2000;
    localparam logic [14:0] F_MDROUT  = 15'h0800;
    localparam logic [14:0] F_MARIN   = 15'h0400;
    localparam logic [14:0] F_ZIN     = 15'h0200;
    localparam logic [14:0] F_PCIN    = 15'h0100;
    localparam logic [14:0] F_MDRIN   = 15'h0080;
    localparam logic [14:0] F_IRIN    = 15'h0040;
    localparam logic [14:0] F_YIN     = 15'h0020;
    localparam logic [14:0] F_INCPC   = 15'h0010;
    localparam logic [14:0] F_READ    = 15'h0008;
    localparam logic [14:0] F_BUSY    = 15'h0004;
    localparam logic [14:0] F_DONE    = 15'h0002;
    localparam logic [14:0] F_ILLEGAL = 15'h0001;

    localparam logic [14:0] EXP_IDLE   = 15'h0000;
    localparam logic [14:0] EXP_T0     = F_PCOUT | F_MARIN | F_INCPC | F_ZIN | F_BUSY;
    localparam logic [14:0] EXP_T1     = F_ZLOWOUT | F_PCIN | F_READ | F_MDRIN | F_BUSY;
    localparam logic [14:0] EXP_T2     = F_MDROUT | F_IRIN | F_BUSY;
    localparam logic [14:0] EXP_T3     = F_YIN | F_BUSY;
    localparam logic [14:0] EXP_T3_ILL = F_ILLEGAL | F_BUSY;
    localparam logic [14:0] EXP_T4     = F_ZIN | F_BUSY;
    localparam logic [14:0] EXP_T5     = F_ZLOWOUT | F_DONE | F_BUSY;

    logic        Clock;
    logic        Clear;
    logic        Run;
    logic [31:0] IR;
    logic        Mem_ready;
    logic        PCout, Zlowout, Zhighout, MDRout;
    logic        MARin, Zin, PCin, MDRin, IRin, Yin;
    logic        IncPC, Read;
    logic [3:0]  CONTROL;
    logic [15:0] Rin;
    logic [15:0] Rout;
    logic        Busy, Done, Illegal;
    logic [14:0] obsFlags;

    int errorCount = 0;
    int checkCount = 0;

    alu_instr_sequencer #(.NREGS(16)) dut (
        .Clock     (Clock),
        .Clear     (Clear),
        .Run       (Run),
        .IR        (IR),
        .Mem_ready (Mem_ready),
        .PCout     (PCout),
        .Zlowout   (Zlowout),
        .Zhighout  (Zhighout),
        .MDRout    (MDRout),
        .MARin     (MARin),
        .Zin       (Zin),
        .PCin      (PCin),
        .MDRin     (MDRin),
        .IRin      (IRin),
        .Yin       (Yin),
        .IncPC     (IncPC),
        .Read      (Read),
        .CONTROL   (CONTROL),
        .Rin       (Rin),
        .Rout      (Rout),
        .Busy      (Busy),
        .Done      (Done),
        .Illegal   (Illegal)
    );

    assign obsFlags = {PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin,
                       IRin, Yin, IncPC, Read, Busy, Done, Illegal};

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Advance one clock and settle just after the rising edge.
    task automatic applyStimulus();
        @(posedge Clock);
        #1;
    endtask

    task automatic checkValue(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
        checkCount++;
        assert (observed === expected)
        else begin
            errorCount++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [14:0] expFlags,
                               input logic [3:0] expControl, input logic [15:0] expRin,
                               input logic [15:0] expRout);
        checkValue({tag, ".flags"},   32'(obsFlags), 32'(expFlags));
        checkValue({tag, ".control"}, 32'(CONTROL),  32'(expControl));
        checkValue({tag, ".rin"},     32'(Rin),      32'(expRin));
        checkValue({tag, ".rout"},    32'(Rout),     32'(expRout));
    endtask

    initial begin
        Clear     = 1'b0;
        Run       = 1'b1;
        IR        = 32'h0;
        Mem_ready = 1'b1;

        // Reset holds IDLE even with Run asserted
        applyStimulus();
        applyStimulus();
        checkOutput("reset", EXP_IDLE, 4'b0000, 16'h0000, 16'h0000);

        Run   = 1'b0;
        Clear = 1'b1;
        applyStimulus();
        checkOutput("idle_after_release", EXP_IDLE, 4'b0000, 16'h0000, 16'h0000);

        // AND R5,R2,R4; Run dropped after T0 must not abort
        Run = 1'b1;
        IR  = 32'h4A920000;
        applyStimulus();
        checkOutput("and_t0", EXP_T0, 4'b0000, 16'h0000, 16'h0000);
        Run = 1'b0;
        applyStimulus();
        checkOutput("and_t1", EXP_T1, 4'b0000, 16'h0000, 16'h0000);
        applyStimulus();
        checkOutput("and_t2", EXP_T2, 4'b0000, 16'h0000, 16'h0000);
        applyStimulus();
        checkOutput("and_t3", EXP_T3, 4'b0000, 16'h0000, 16'h0004);
        applyStimulus();
        checkOutput("and_t4", EXP_T4, 4'b0000, 16'h0000, 16'h0010);
        applyStimulus();
        checkOutput("and_t5", EXP_T5, 4'b0000, 16'h0020, 16'h0000);
        applyStimulus();
        checkOutput("and_idle", EXP_IDLE, 4'b0000, 16'h0000, 16'h0000);

        // ADD with a 3-cycle memory stall, then a second ADD back-to-back
        Run       = 1'b1;
        IR        = 32'h1A920000;
        Mem_ready = 1'b0;
        applyStimulus();
        checkOutput("add1_t0", EXP_T0, 4'b0000, 16'h0000, 16'h0000);
        applyStimulus();
        checkOutput("stall_t1_c1", EXP_T1, 4'b0000, 16'h0000, 16'h0000);
        applyStimulus();
        checkOutput("stall_t1_c2", EXP_T1, 4'b0000, 16'h0000, 16'h0000);
        applyStimulus();
        checkOutput("stall_t1_c3", EXP_T1, 4'b0000, 16'h0000, 16'h0000);
        applyStimulus();
        checkOutput("stall_t1_c4", EXP_T1, 4'b0000, 16'h0000, 16'h0000);
        Mem_ready = 1'b1;
        applyStimulus();
        checkOutput("add1_t2", EXP_T2, 4'b0000, 16'h0000, 16'h0000);
        applyStimulus();
        checkOutput("add1_t3", EXP_T3, 4'b0000, 16'h0000, 16'h0004);
        applyStimulus();
        checkOutput("add1_t4", EXP_T4, 4'b0010, 16'h0000, 16'h0010);
        applyStimulus();
        checkOutput("add1_t5", EXP_T5, 4'b0000, 16'h0020, 16'h0000);
        applyStimulus();
        checkOutput("add2_t0", EXP_T0, 4'b0000, 16'h0000, 16'h0000);
        applyStimulus();
        checkOutput("add2_t1", EXP_T1, 4'b0000, 16'h0000, 16'h0000);
        applyStimulus();
        checkOutput("add2_t2", EXP_T2, 4'b0000, 16'h0000, 16'h0000);
        applyStimulus();
        checkOutput("add2_t3", EXP_T3, 4'b0000, 16'h0000, 16'h0004);
        applyStimulus();
        checkOutput("add2_t4", EXP_T4, 4'b0010, 16'h0000, 16'h0010);
        applyStimulus();
        checkOutput("add2_t5", EXP_T5, 4'b0000, 16'h0020, 16'h0000);
        Run = 1'b0;
        applyStimulus();
        checkOutput("add2_idle", EXP_IDLE, 4'b0000, 16'h0000, 16'h0000);

        // Illegal opcode returns to IDLE even though Run is still high
        Run = 1'b1;
        IR  = 32'hF8000000;
        applyStimulus();
        checkOutput("ill_t0", EXP_T0, 4'b0000, 16'h0000, 16'h0000);
        applyStimulus();
        checkOutput("ill_t1", EXP_T1, 4'b0000, 16'h0000, 16'h0000);
        applyStimulus();
        checkOutput("ill_t2", EXP_T2, 4'b0000, 16'h0000, 16'h0000);
        applyStimulus();
        checkOutput("ill_t3", EXP_T3_ILL, 4'b0000, 16'h0000, 16'h0000);
        applyStimulus();
        checkOutput("ill_idle", EXP_IDLE, 4'b0000, 16'h0000, 16'h0000);

        // Asynchronous clear in the middle of T4
        IR = 32'h4A920000;
        applyStimulus();
        checkOutput("clr_t0", EXP_T0, 4'b0000, 16'h0000, 16'h0000);
        applyStimulus();
        applyStimulus();
        applyStimulus();
        checkOutput("clr_t3", EXP_T3, 4'b0000, 16'h0000, 16'h0004);
        applyStimulus();
        checkOutput("clr_t4", EXP_T4, 4'b0000, 16'h0000, 16'h0010);
        #2;
        Clear = 1'b0;
        #1;
        checkOutput("clr_async", EXP_IDLE, 4'b0000, 16'h0000, 16'h0000);
        applyStimulus();
        checkOutput("clr_held", EXP_IDLE, 4'b0000, 16'h0000, 16'h0000);

        // Restart with SHR R15,R0,R7 covering the register-field extremes
        Clear = 1'b1;
        IR    = 32'h2F838000;
        applyStimulus();
        checkOutput("shr_t0", EXP_T0, 4'b0000, 16'h0000, 16'h0000);
        Run = 1'b0;
        applyStimulus();
        checkOutput("shr_t1", EXP_T1, 4'b0000, 16'h0000, 16'h0000);
        applyStimulus();
        checkOutput("shr_t2", EXP_T2, 4'b0000, 16'h0000, 16'h0000);
        applyStimulus();
        checkOutput("shr_t3", EXP_T3, 4'b0000, 16'h0000, 16'h0001);
        applyStimulus();
        checkOutput("shr_t4", EXP_T4, 4'b0100, 16'h0000, 16'h0080);
        applyStimulus();
        checkOutput("shr_t5", EXP_T5, 4'b0000, 16'h8000, 16'h0000);
        applyStimulus();
        checkOutput("shr_idle", EXP_IDLE, 4'b0000, 16'h0000, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
